// File: rtl/gpu_apb_cmd_queue_pkg.sv
// Shared definitions for the GPU APB command queue.
// Opcodes, register addresses and status bit positions.
package gpu_apb_cmd_queue_pkg;

    // Opcodes issued by host software
    localparam logic [3:0] OP_FILL = 4'h2;
    localparam logic [3:0] OP_LINE = 4'h3;
    localparam logic [3:0] OP_BLIT = 4'h7;

    // Register map defaults
    localparam logic [7:0] CMD_ADDR_DEF  = 8'h00;
    localparam logic [7:0] STAT_ADDR_DEF = 8'h04;

    // Status register layout: [8:0] count
    localparam int STAT_EMPTY_BIT = 9;
    localparam int STAT_FULL_BIT  = 10;
    localparam int STAT_OVF_BIT   = 11;

    localparam int CNT_W = 9;

endpackage

// File: rtl/gpu_apb_cmd_queue_fifo.sv
// gpu_cmd_fifo: synchronous show-ahead FIFO.
// Ports: push/wdata, pop/rdata (head), full, empty, count.
module gpu_cmd_fifo
    import gpu_apb_cmd_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    // A push into a full FIFO is accepted only when a pop frees a slot
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gpu_apb_cmd_queue.sv
// APB slave front end: queues draw commands for the decoder.
// Ports: APB slave, cmd valid/ready stream, full and overflow.
module gpu_apb_cmd_queue
    import gpu_apb_cmd_queue_pkg::*;
#(
    parameter int         DEPTH     = 8,
    parameter logic [7:0] CMD_ADDR  = CMD_ADDR_DEF,
    parameter logic [7:0] STAT_ADDR = STAT_ADDR_DEF
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [31:0] pAddr_i,
    input  logic [31:0] pDataWrite_i,
    input  logic        pSel_i,
    input  logic        pEnable_i,
    input  logic        pWrite_i,
    output logic [31:0] pDataRead_o,
    output logic        cmd_valid_o,
    output logic [3:0]  cmd_opcode_o,
    output logic [27:0] cmd_payload_o,
    input  logic        cmd_ready_i,
    output logic        fifo_full_o,
    output logic        overflow_o
);

    logic             access;
    logic             wr_cmd;
    logic             wr_stat;
    logic             rd_stat;
    logic [7:0]       addr;
    logic             pop;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic [31:0]      head;
    logic             unused_addr;

    assign unused_addr = ^pAddr_i[31:8];

    assign addr    = pAddr_i[7:0];
    assign access  = pSel_i && pEnable_i;
    assign wr_cmd  = access && pWrite_i && (addr == CMD_ADDR);
    assign wr_stat = access && pWrite_i && (addr == STAT_ADDR);
    assign rd_stat = access && !pWrite_i && (addr == STAT_ADDR);

    assign pop = cmd_valid_o && cmd_ready_i;

    gpu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (wr_cmd),
        .wdata (pDataWrite_i),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign cmd_valid_o   = !empty;
    assign fifo_full_o   = full;
    // Head is zeroed while empty so stale RAM never leaks out
    assign cmd_opcode_o  = empty ? 4'h0 : head[31:28];
    assign cmd_payload_o = empty ? 28'h0 : head[27:0];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            overflow_o <= 1'b0;
        end else if (wr_stat) begin
            overflow_o <= 1'b0;
        end else if (wr_cmd && full && !pop) begin
            overflow_o <= 1'b1;
        end
    end

    always_comb begin
        pDataRead_o = 32'h0;
        if (rd_stat) begin
            pDataRead_o[CNT_W-1:0]      = count;
            pDataRead_o[STAT_EMPTY_BIT] = empty;
            pDataRead_o[STAT_FULL_BIT]  = full;
            pDataRead_o[STAT_OVF_BIT]   = overflow_o;
        end
    end

endmodule

// File: tb/tb_gpu_apb_cmd_queue.sv
// Testbench for gpu_apb_cmd_queue.
// Table-driven APB vectors plus hand sequences for corners.
module tb_gpu_apb_cmd_queue;
    import gpu_apb_cmd_queue_pkg::*;

    logic        tb_clk = 1'b0;
    logic        n_rst  = 1'b0;
    logic [31:0] paddr  = '0;
    logic [31:0] pwdata = '0;
    logic        psel   = 1'b0;
    logic        pen    = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] prdata;
    logic        cmd_valid;
    logic [3:0]  cmd_opcode;
    logic [27:0] cmd_payload;
    logic        cmd_ready = 1'b0;
    logic        fifo_full;
    logic        overflow;

    int passed = 0;
    int total  = 0;
    logic pre_valid;

    always #5 tb_clk = ~tb_clk;

    gpu_apb_cmd_queue dut (
        .clk           (tb_clk),
        .n_rst         (n_rst),
        .pAddr_i       (paddr),
        .pDataWrite_i  (pwdata),
        .pSel_i        (psel),
        .pEnable_i     (pen),
        .pWrite_i      (pwrite),
        .pDataRead_o   (prdata),
        .cmd_valid_o   (cmd_valid),
        .cmd_opcode_o  (cmd_opcode),
        .cmd_payload_o (cmd_payload),
        .cmd_ready_i   (cmd_ready),
        .fifo_full_o   (fifo_full),
        .overflow_o    (overflow)
    );

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge tb_clk);
        psel = 1'b1; pen = 1'b0; pwrite = 1'b1;
        paddr = {24'h0, a}; pwdata = d;
        @(negedge tb_clk);
        pen = 1'b1;
        #1 pre_valid = cmd_valid;
        @(negedge tb_clk);
        psel = 1'b0; pen = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge tb_clk);
        psel = 1'b1; pen = 1'b0; pwrite = 1'b0;
        paddr = {24'h0, a};
        @(negedge tb_clk);
        pen = 1'b1;
        #1 d = prdata;
        @(negedge tb_clk);
        psel = 1'b0; pen = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        chk_pre;
        logic        exp_valid;
        logic [3:0]  exp_op;
        logic [27:0] exp_pl;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [31:0] rd;

        vecs[0] = '{1'b1, 8'h00, 32'h300000c8, 1'b1, 1'b1, OP_LINE, 28'h00000c8, 32'h0};
        vecs[1] = '{1'b1, 8'h00, 32'h20032140, 1'b0, 1'b1, OP_LINE, 28'h00000c8, 32'h0};
        vecs[2] = '{1'b1, 8'h00, 32'h70ffffff, 1'b0, 1'b1, OP_LINE, 28'h00000c8, 32'h0};
        vecs[3] = '{1'b0, 8'h04, 32'h0,        1'b0, 1'b1, OP_LINE, 28'h00000c8, 32'h00000003};
        vecs[4] = '{1'b0, 8'h00, 32'h0,        1'b0, 1'b1, OP_LINE, 28'h00000c8, 32'h0};
        vecs[5] = '{1'b0, 8'h08, 32'h0,        1'b0, 1'b1, OP_LINE, 28'h00000c8, 32'h0};
        vecs[6] = '{1'b1, 8'h08, 32'h5eadbeef, 1'b0, 1'b1, OP_LINE, 28'h00000c8, 32'h0};
        vecs[7] = '{1'b0, 8'h04, 32'h0,        1'b0, 1'b1, OP_LINE, 28'h00000c8, 32'h00000003};

        // Reset, then a reset asserted in the middle of an access
        repeat (2) @(negedge tb_clk);
        n_rst = 1'b1;
        apb_write(8'h00, 32'h20000001);
        check("pre_reset_valid", {31'b0, cmd_valid}, 32'h1);
        @(negedge tb_clk);
        psel = 1'b1; pen = 1'b0; pwrite = 1'b1;
        paddr = 32'h0; pwdata = 32'h30000002;
        @(negedge tb_clk);
        pen = 1'b1;
        #2 n_rst = 1'b0;
        #1;
        check("rst_valid", {31'b0, cmd_valid}, 32'h0);
        check("rst_opcode", {28'b0, cmd_opcode}, 32'h0);
        check("rst_payload", {4'b0, cmd_payload}, 32'h0);
        check("rst_full", {31'b0, fifo_full}, 32'h0);
        check("rst_ovf", {31'b0, overflow}, 32'h0);
        check("rst_rdata", prdata, 32'h0);
        @(negedge tb_clk);
        psel = 1'b0; pen = 1'b0; pwrite = 1'b0;
        @(negedge tb_clk);
        n_rst = 1'b1;
        apb_read(8'h04, rd);
        check("rst_status", rd, 32'h00000200);

        // Table vectors, downstream stalled
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].wr) begin
                apb_write(vecs[i].addr, vecs[i].wdata);
                if (vecs[i].chk_pre) begin
                    check($sformatf("v%0d_pre_valid", i),
                          {31'b0, pre_valid}, 32'h0);
                end
            end else begin
                apb_read(vecs[i].addr, rd);
                check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
            end
            check($sformatf("v%0d_valid", i),
                  {31'b0, cmd_valid}, {31'b0, vecs[i].exp_valid});
            check($sformatf("v%0d_op", i),
                  {28'b0, cmd_opcode}, {28'b0, vecs[i].exp_op});
            check($sformatf("v%0d_pl", i),
                  {4'b0, cmd_payload}, {4'b0, vecs[i].exp_pl});
        end

        // Setup-only cycles and enable without select do nothing
        @(negedge tb_clk);
        psel = 1'b1; pen = 1'b0; pwrite = 1'b0; paddr = 32'h4;
        #1 check("setup_rdata", prdata, 32'h0);
        @(negedge tb_clk);
        pwrite = 1'b1; paddr = 32'h0; pwdata = 32'h11111111;
        @(negedge tb_clk);
        psel = 1'b0; pen = 1'b1;
        @(negedge tb_clk);
        pen = 1'b0; pwrite = 1'b0;
        apb_read(8'h04, rd);
        check("setup_no_push", rd, 32'h00000003);

        // Drain three commands
        cmd_ready = 1'b1;
        check("drain0", {cmd_opcode, cmd_payload}, 32'h300000c8);
        @(negedge tb_clk);
        check("drain1", {cmd_opcode, cmd_payload}, 32'h20032140);
        @(negedge tb_clk);
        check("drain2", {cmd_opcode, cmd_payload}, 32'h70ffffff);
        @(negedge tb_clk);
        cmd_ready = 1'b0;
        check("drain_valid", {31'b0, cmd_valid}, 32'h0);
        check("drain_out", {cmd_opcode, cmd_payload}, 32'h0);

        // Fill, then overflow
        for (int i = 0; i < 8; i++) begin
            apb_write(8'h00, 32'h10000000 + i);
        end
        check("fill_full", {31'b0, fifo_full}, 32'h1);
        check("fill_ovf", {31'b0, overflow}, 32'h0);
        apb_write(8'h00, 32'h99999999);
        check("ovf_set", {31'b0, overflow}, 32'h1);
        apb_read(8'h04, rd);
        check("ovf_status", rd, 32'h00000C08);
        apb_write(8'h04, 32'hffffffff);
        check("ovf_clear", {31'b0, overflow}, 32'h0);
        check("ovf_full", {31'b0, fifo_full}, 32'h1);
        check("ovf_head", {cmd_opcode, cmd_payload}, 32'h10000000);

        // Push and pop on the same edge while full
        @(negedge tb_clk);
        psel = 1'b1; pen = 1'b0; pwrite = 1'b1;
        paddr = 32'h0; pwdata = 32'hA5A5A5A5;
        @(negedge tb_clk);
        pen = 1'b1; cmd_ready = 1'b1;
        @(negedge tb_clk);
        psel = 1'b0; pen = 1'b0; pwrite = 1'b0; cmd_ready = 1'b0;
        check("pp_ovf", {31'b0, overflow}, 32'h0);
        apb_read(8'h04, rd);
        check("pp_status", rd, 32'h00000408);

        // Drain through the pointer wrap
        cmd_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            check($sformatf("wrap%0d", i),
                  {cmd_opcode, cmd_payload}, 32'h10000000 + i);
            @(negedge tb_clk);
        end
        check("wrap_last", {cmd_opcode, cmd_payload}, 32'hA5A5A5A5);
        @(negedge tb_clk);
        cmd_ready = 1'b0;
        check("wrap_empty", {31'b0, cmd_valid}, 32'h0);
        apb_read(8'h04, rd);
        check("wrap_status", rd, 32'h00000200);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
